// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the SDRAM-side Wishbone arbiter.
// The state encoding and Wishbone cycle-type codes are shared by the RTL and the bench.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: the lowest requesting index at or after ptr wins.
// The search wraps modulo NCH.
module wb_rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] win,
  output logic [IW-1:0]  win_idx
);

  logic found;
  int   j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (!found && req[j]) begin
        found      = 1'b1;
        win[j]     = 1'b1;
        win_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// N-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// A grant is held for a whole cycle or burst, and a per-transfer ack watchdog aborts hung cycles.
//
// state | meaning
// IDLE  | no owner; slave outputs forced low; arbitrate when init is done
// GRANT | granted master muxed onto the slave; ack routed back; watchdog running
// ABORT | watchdog expired; slave cycle dropped; wait for the master to release cyc
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  sys_clk,
  input  logic                  wb_rst_i,
  input  logic                  sdr_init_done,
  input  logic [NCH-1:0]        m_cyc_i,
  input  logic [NCH-1:0]        m_stb_i,
  input  logic [NCH-1:0]        m_we_i,
  input  logic [NCH*APP_AW-1:0] m_addr_i,
  input  logic [NCH*dw-1:0]     m_dat_i,
  input  logic [NCH*dw/8-1:0]   m_sel_i,
  input  logic [NCH*3-1:0]      m_cti_i,
  output logic [NCH-1:0]        m_ack_o,
  output logic [NCH-1:0]        m_err_o,
  output logic [dw-1:0]         m_dat_o,
  output logic [NCH-1:0]        gnt_o,
  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  output logic                  s_wb_we_o,
  output logic [APP_AW-1:0]     s_wb_addr_o,
  output logic [dw-1:0]         s_wb_dat_o,
  output logic [dw/8-1:0]       s_wb_sel_o,
  output logic [2:0]            s_wb_cti_o,
  input  logic                  s_wb_ack_i,
  input  logic [dw-1:0]         s_wb_dat_i
);

  localparam int IW = $clog2(NCH);
  localparam int WW = $clog2(TIMEOUT);
  localparam int SW = dw / 8;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  arb_state_e     state;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  g_idx;
  logic [IW-1:0]  ptr;
  logic [WW-1:0]  wd_cnt;
  logic [NCH-1:0] err_q;

  logic [NCH-1:0] req;
  logic [NCH-1:0] win;
  logic [IW-1:0]  win_idx;
  logic           g_cyc;
  logic           g_stb;
  logic [2:0]     g_cti;

  assign req = m_cyc_i & m_stb_i;

  wb_rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  assign g_cyc = m_cyc_i[g_idx];
  assign g_stb = m_stb_i[g_idx];
  assign g_cti = m_cti_i[int'(g_idx)*3 +: 3];

  always_ff @(posedge sys_clk) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      gnt    <= '0;
      g_idx  <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
      err_q  <= '0;
    end else begin
      err_q <= '0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (sdr_init_done && (|req)) begin
            gnt   <= win;
            g_idx <= win_idx;
            ptr   <= (win_idx == IW'(NCH - 1)) ? '0 : win_idx + IW'(1);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!g_cyc) begin
            gnt    <= '0;
            wd_cnt <= '0;
            state  <= IDLE;
          end else if (s_wb_ack_i) begin
            // an ack on the expiry cycle still wins over the watchdog
            wd_cnt <= '0;
            if (g_cti == CTI_EOB) begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else if (g_stb) begin
            if (wd_cnt == WD_LAST) begin
              err_q  <= gnt;
              wd_cnt <= '0;
              state  <= ABORT;
            end else begin
              wd_cnt <= wd_cnt + WW'(1);
            end
          end
        end
        ABORT: begin
          if (!g_cyc) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_addr_o = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    s_wb_cti_o  = '0;
    m_ack_o     = '0;
    if (state == GRANT) begin
      s_wb_cyc_o  = g_cyc;
      s_wb_stb_o  = g_stb;
      s_wb_we_o   = m_we_i[g_idx];
      s_wb_addr_o = m_addr_i[int'(g_idx)*APP_AW +: APP_AW];
      s_wb_dat_o  = m_dat_i[int'(g_idx)*dw +: dw];
      s_wb_sel_o  = m_sel_i[int'(g_idx)*SW +: SW];
      s_wb_cti_o  = g_cti;
      m_ack_o     = gnt & {NCH{s_wb_ack_i}};
    end
  end

  assign m_dat_o = s_wb_dat_i;
  assign m_err_o = err_q;
  assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: init gating, round-robin order, burst hold,
// watchdog abort, ack on the expiry cycle and reset in the middle of a burst.
module tb_wb_sdram_arbiter;
  import wb_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int N  = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_dat;
  logic [N*DW/8-1:0] m_sel;
  logic [N*3-1:0]    m_cti;
  logic [N-1:0]      m_ack_o, m_err_o, gnt_o;
  logic [DW-1:0]     m_dat_o;
  logic              s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
  logic [AW-1:0]     s_wb_addr_o;
  logic [DW-1:0]     s_wb_dat_o;
  logic [DW/8-1:0]   s_wb_sel_o;
  logic [2:0]        s_wb_cti_o;
  logic              s_ack;
  logic [DW-1:0]     s_dat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_sdram_arbiter #(
    .dw      (DW),
    .APP_AW  (AW),
    .NCH     (N),
    .TIMEOUT (TO)
  ) dut (
    .sys_clk       (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init_done),
    .m_cyc_i       (m_cyc),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_addr_i      (m_addr),
    .m_dat_i       (m_dat),
    .m_sel_i       (m_sel),
    .m_cti_i       (m_cti),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .m_dat_o       (m_dat_o),
    .gnt_o         (gnt_o),
    .s_wb_cyc_o    (s_wb_cyc_o),
    .s_wb_stb_o    (s_wb_stb_o),
    .s_wb_we_o     (s_wb_we_o),
    .s_wb_addr_o   (s_wb_addr_o),
    .s_wb_dat_o    (s_wb_dat_o),
    .s_wb_sel_o    (s_wb_sel_o),
    .s_wb_cti_o    (s_wb_cti_o),
    .s_wb_ack_i    (s_ack),
    .s_wb_dat_i    (s_dat)
  );

  function automatic logic [AW-1:0] exp_addr(input int i);
    return 26'h0A0_0000 + AW'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic on, input logic [2:0] c);
    m_cyc[i]         = on;
    m_stb[i]         = on;
    m_we[i]          = on;
    m_cti[i*3 +: 3]  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b1; s_ack = 1'b0; s_dat = 32'hA5A5_0001;
    for (int i = 0; i < N; i++) drive(i, 1'b1, CTI_EOB);
    step(); step();
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    checks++; if ({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o} !== 3'b000) begin failures++; $display("FAIL reset_ctl: got %b want 000", {s_wb_cyc_o, s_wb_stb_o, s_wb_we_o}); end
    checks++; if (s_wb_addr_o !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", s_wb_addr_o); end
    checks++; if ({m_ack_o, m_err_o} !== 8'h00) begin failures++; $display("FAIL reset_ack_err: got %h want 00", {m_ack_o, m_err_o}); end
    checks++; if (m_dat_o !== 32'hA5A5_0001) begin failures++; $display("FAIL reset_dat: got %h want a5a50001", m_dat_o); end
    for (int i = 0; i < N; i++) drive(i, 1'b0, CTI_CLASSIC);
    rst = 1'b0;
  endtask

  task automatic test_init_gating();
    init_done = 1'b0;
    drive(0, 1'b1, CTI_EOB);
    for (int c = 0; c < 20; c++) begin
      step();
      checks++; if ({s_wb_cyc_o, gnt_o} !== 5'b0) begin failures++; $display("FAIL init_gate c=%0d: cyc/gnt %b want 00000", c, {s_wb_cyc_o, gnt_o}); end
    end
    init_done = 1'b1;
    step();
    checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL init_grant: got %b want 0001", gnt_o); end
    checks++; if (s_wb_cyc_o !== 1'b1 || s_wb_addr_o !== exp_addr(0)) begin failures++; $display("FAIL init_mux: cyc %b addr %h want 1 %h", s_wb_cyc_o, s_wb_addr_o, exp_addr(0)); end
    s_ack = 1'b1; #1;
    checks++; if (m_ack_o !== 4'b0001) begin failures++; $display("FAIL init_ack: got %b want 0001", m_ack_o); end
    step();
    s_ack = 1'b0; drive(0, 1'b0, CTI_CLASSIC); #1;
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL init_release: got %b want 0000", gnt_o); end
    step();
  endtask

  task automatic test_round_robin();
    int e;
    logic [N-1:0] want;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 1'b1, CTI_EOB);
    step();
    for (int n = 0; n < 5; n++) begin
      e = n % N;
      want = '0; want[e] = 1'b1;
      checks++; if (gnt_o !== want) begin failures++; $display("FAIL rr_gnt n=%0d: got %b want %b", n, gnt_o, want); end
      checks++; if (s_wb_addr_o !== exp_addr(e) || s_wb_dat_o !== 32'hD000_0000 + DW'(e)) begin failures++; $display("FAIL rr_mux n=%0d: addr %h dat %h want %h", n, s_wb_addr_o, s_wb_dat_o, exp_addr(e)); end
      s_ack = 1'b1; #1;
      checks++; if (m_ack_o !== want) begin failures++; $display("FAIL rr_ack n=%0d: got %b want %b", n, m_ack_o, want); end
      step();
      s_ack = 1'b0; drive(e, 1'b0, CTI_CLASSIC); #1;
      checks++; if (gnt_o !== 4'b0000 || s_wb_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_idle n=%0d: gnt %b cyc %b want 0000 0", n, gnt_o, s_wb_cyc_o); end
      step();
      if (n < 4) drive(e, 1'b1, CTI_EOB);
    end
    for (int i = 0; i < N; i++) drive(i, 1'b0, CTI_CLASSIC);
    step(); step();
  endtask

  task automatic test_burst_hold();
    drive(0, 1'b1, CTI_EOB);
    drive(2, 1'b1, CTI_INCR);
    step();
    checks++; if (gnt_o !== 4'b0100) begin failures++; $display("FAIL burst_gnt: got %b want 0100", gnt_o); end
    for (int b = 0; b < 4; b++) begin
      m_cti[2*3 +: 3] = (b == 3) ? CTI_EOB : CTI_INCR;
      s_ack = 1'b1; s_dat = 32'hB000_0000 + DW'(b);
      if (b == 1) init_done = 1'b0;
      if (b == 3) init_done = 1'b1;
      #1;
      checks++; if (gnt_o !== 4'b0100 || m_ack_o !== 4'b0100) begin failures++; $display("FAIL burst_beat b=%0d: gnt %b ack %b want 0100 0100", b, gnt_o, m_ack_o); end
      checks++; if (m_dat_o !== 32'hB000_0000 + DW'(b)) begin failures++; $display("FAIL burst_dat b=%0d: got %h", b, m_dat_o); end
      step();
    end
    s_ack = 1'b0; drive(2, 1'b0, CTI_CLASSIC); #1;
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL burst_turn: got %b want 0000", gnt_o); end
    step();
    checks++; if (gnt_o !== 4'b0001 || s_wb_addr_o !== exp_addr(0)) begin failures++; $display("FAIL burst_next: gnt %b addr %h want 0001 %h", gnt_o, s_wb_addr_o, exp_addr(0)); end
    s_ack = 1'b1;
    step();
    s_ack = 1'b0; drive(0, 1'b0, CTI_CLASSIC);
    step();
  endtask

  task automatic test_timeout();
    drive(1, 1'b1, CTI_INCR);
    step();
    checks++; if (gnt_o !== 4'b0010 || s_wb_cyc_o !== 1'b1) begin failures++; $display("FAIL to_gnt: gnt %b cyc %b want 0010 1", gnt_o, s_wb_cyc_o); end
    for (int c = 1; c < TO; c++) begin
      step();
      checks++; if (m_err_o !== 4'b0000 || s_wb_cyc_o !== 1'b1) begin failures++; $display("FAIL to_wait c=%0d: err %b cyc %b want 0000 1", c, m_err_o, s_wb_cyc_o); end
    end
    step();
    checks++; if (m_err_o !== 4'b0010 || s_wb_cyc_o !== 1'b0 || s_wb_stb_o !== 1'b0) begin failures++; $display("FAIL to_err: err %b cyc %b stb %b want 0010 0 0", m_err_o, s_wb_cyc_o, s_wb_stb_o); end
    s_ack = 1'b1; #1;
    checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL to_late_ack: got %b want 0000", m_ack_o); end
    step();
    checks++; if (m_err_o !== 4'b0000 || m_ack_o !== 4'b0000) begin failures++; $display("FAIL to_pulse: err %b ack %b want 0000 0000", m_err_o, m_ack_o); end
    s_ack = 1'b0; drive(1, 1'b0, CTI_CLASSIC);
    step();
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL to_idle: got %b want 0000", gnt_o); end
  endtask

  task automatic test_ack_at_expiry();
    drive(2, 1'b1, CTI_EOB);
    step();
    checks++; if (gnt_o !== 4'b0100) begin failures++; $display("FAIL exp_gnt: got %b want 0100", gnt_o); end
    for (int c = 1; c < TO; c++) step();
    s_ack = 1'b1; #1;
    checks++; if (m_ack_o !== 4'b0100 || m_err_o !== 4'b0000) begin failures++; $display("FAIL exp_ack: ack %b err %b want 0100 0000", m_ack_o, m_err_o); end
    step();
    checks++; if (m_err_o !== 4'b0000 || gnt_o !== 4'b0000 || s_wb_cyc_o !== 1'b0) begin failures++; $display("FAIL exp_done: err %b gnt %b cyc %b want 0000 0000 0", m_err_o, gnt_o, s_wb_cyc_o); end
    s_ack = 1'b0; drive(2, 1'b0, CTI_CLASSIC);
    step();
    checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL exp_noerr: got %b want 0000", m_err_o); end
  endtask

  task automatic test_reset_mid_burst();
    drive(3, 1'b1, CTI_INCR);
    step();
    checks++; if (gnt_o !== 4'b1000) begin failures++; $display("FAIL rmb_gnt: got %b want 1000", gnt_o); end
    s_ack = 1'b1;
    step();
    for (int i = 0; i < 3; i++) drive(i, 1'b1, CTI_EOB);
    rst = 1'b1; #1;
    checks++; if (m_ack_o !== 4'b1000) begin failures++; $display("FAIL rmb_beat2: got %b want 1000", m_ack_o); end
    step();
    checks++; if ({gnt_o, m_ack_o, m_err_o} !== 12'h000) begin failures++; $display("FAIL rmb_outs: gnt/ack/err %h want 000", {gnt_o, m_ack_o, m_err_o}); end
    checks++; if ({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_cti_o} !== 6'b0 || s_wb_addr_o !== '0) begin failures++; $display("FAIL rmb_slave: ctl %b addr %h want 0", {s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_cti_o}, s_wb_addr_o); end
    rst = 1'b0; s_ack = 1'b0;
    m_cti[3*3 +: 3] = CTI_EOB;
    step();
    checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL rmb_ptr: got %b want 0001", gnt_o); end
    for (int i = 0; i < N; i++) drive(i, 1'b0, CTI_CLASSIC);
    step(); step();
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; s_ack = 1'b0; s_dat = '0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_sel = '1;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW] = exp_addr(i);
      m_dat[i*DW +: DW]  = 32'hD000_0000 + DW'(i);
    end
    test_reset();
    test_init_gating();
    test_round_robin();
    test_burst_hold();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
